// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit for stage E: HI/LO registers, pending result
// latched at start, released after a fixed busy latency.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_req_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_hi_p;
  logic [31:0]        r_lo_p;
  logic               r_p_valid;

  logic               w_start;
  logic               w_is_div;
  logic               w_div_zero;
  logic [31:0]        w_divisor;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_sq_mag;
  logic [31:0]        w_sr_mag;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic [CNT_W-1:0]   w_n_m1;

  assign w_start    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign w_is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign w_div_zero = (rt_val == 32'd0);
  // Substitute 1 for a zero divisor so the dividers never see x/0; the result is discarded anyway.
  assign w_divisor  = w_div_zero ? 32'd1 : rt_val;

  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
  assign w_a_neg  = rs_val[31];
  assign w_b_neg  = w_divisor[31];
  assign w_a_mag  = w_a_neg ? 32'(-rs_val) : rs_val;
  assign w_b_mag  = w_b_neg ? 32'(-w_divisor) : w_divisor;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md_op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        w_res_lo = (w_a_neg ^ w_b_neg) ? 32'(-w_sq_mag) : w_sq_mag;
        w_res_hi = w_a_neg ? 32'(-w_sr_mag) : w_sr_mag;
      end
      OP_DIVU: begin
        w_res_lo = rs_val / w_divisor;
        w_res_hi = rs_val % w_divisor;
      end
      default: ;
    endcase
  end

  assign w_n_m1 = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  // Sequencer: IDLE accepts starts and MTHI/MTLO; BUSY ignores all ops until the count expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_hi_p    <= 32'd0;
      r_lo_p    <= 32'd0;
      r_p_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_hi_p    <= w_res_hi;
            r_lo_p    <= w_res_lo;
            r_p_valid <= !(w_is_div && w_div_zero);
            r_cnt     <= w_n_m1;
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
          end else if (md_op == OP_MTHI) begin
            r_hi <= rs_val;
          end else if (md_op == OP_MTLO) begin
            r_lo <= rs_val;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            if (r_p_valid) begin
              r_hi <= r_hi_p;
              r_lo <= r_lo_p;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = md_req_d & (w_start | r_busy);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed cases with literal results plus randomized
// traffic checked every cycle against a cycles-remaining behavioural model.
module tb_md_unit_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_req_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .md_req_d(md_req_d), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in flight, plus the result to commit when it reaches zero.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_pv;
  int          m_left;

  always @(posedge clk or negedge reset) begin
    longint          a_s, b_s, q, r;
    longint unsigned a_u, b_u;
    logic [63:0]     p;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_pv = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pv) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else begin
      a_s = $signed(rs_val); b_s = $signed(rt_val);
      a_u = rs_val;          b_u = rt_val;
      case (md_op)
        3'd1: begin p = a_s * b_s; m_ph = p[63:32]; m_pl = p[31:0]; m_pv = 1; m_left = MULT_N; end
        3'd2: begin p = a_u * b_u; m_ph = p[63:32]; m_pl = p[31:0]; m_pv = 1; m_left = MULT_N; end
        3'd3: begin
          m_pv = (rt_val != 0); m_left = DIV_N;
          if (m_pv) begin q = a_s / b_s; r = a_s % b_s; m_pl = q[31:0]; m_ph = r[31:0]; end
        end
        3'd4: begin
          m_pv = (rt_val != 0); m_left = DIV_N;
          if (m_pv) begin m_pl = 32'(a_u / b_u); m_ph = 32'(a_u % b_u); end
        end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = md_req_d && ((md_op >= 3'd1 && md_op <= 3'd4) || m_left > 0);
      chk("cyc_busy",  32'(busy),     32'(m_left > 0));
      chk("cyc_stall", 32'(md_stall), 32'(exp_stall));
      chk("cyc_hi",    hi, m_hi);
      chk("cyc_lo",    lo, m_lo);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; rs_val = a; rt_val = b;
    cyc(1);
    md_op = 3'd0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int i = 0; i < n; i++) begin
      chk({name, "_busy"}, 32'(busy), 32'd1);
      cyc(1);
    end
    chk({name, "_done"}, 32'(busy), 32'd0);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    chk({name, "_model_hi"}, m_hi, exp_hi);
    chk({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  initial begin
    logic [31:0] corner [4];
    reset = 1'b0; md_op = 3'd0; rs_val = 0; rt_val = 0; md_req_d = 1'b0;
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    cyc(2);
    reset = 1'b1;
    chk_en = 1;
    for (int r = 0; r < 2; r++) begin
      md_req_d = r[0];
      cyc(1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_stall", 32'(md_stall), 32'd0);
      chk("idle_hi", hi, 32'd0);
      chk("idle_lo", lo, 32'd0);
    end
    md_req_d = 1'b0;

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 3'd4, 32'd7,         32'd0, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

    // Stall while held in D, and a second MULT during BUSY is ignored.
    md_req_d = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    #1 chk("stall_start", 32'(md_stall), 32'd1);
    cyc(1);
    rs_val = 32'd100; rt_val = 32'd100;
    for (int i = 0; i < int'(MULT_N); i++) begin
      if (i == 2) md_op = 3'd0;
      chk("stall_busy", 32'(md_stall), 32'd1);
      cyc(1);
    end
    chk("stall_after", 32'(md_stall), 32'd0);
    chk("stall_hi", hi, 32'd0);
    chk("stall_lo", lo, 32'd12);
    md_req_d = 1'b0;

    issue(3'd5, 32'h1234, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd12);
    chk("mthi_busy", 32'(busy), 32'd0);

    // Reset in the third busy cycle of a DIV aborts it for good.
    issue(3'd3, 32'd100, 32'd7);
    cyc(2);
    reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(DIV_N + 2);
    chk("rstmid_late_hi", hi, 32'd0);
    chk("rstmid_late_lo", lo, 32'd0);
    chk("rstmid_late_busy", 32'(busy), 32'd0);

    // Randomized traffic, including ops during BUSY and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      md_op    = 3'($urandom_range(0, 7));
      rs_val   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      case ($urandom_range(0, 5))
        0:       rt_val = 32'd0;
        1:       rt_val = corner[$urandom_range(0, 3)];
        2:       rt_val = 32'($urandom_range(1, 9));
        default: rt_val = $urandom;
      endcase
      md_req_d = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    reset = 1'b1; md_op = 3'd0;
    cyc(DIV_N + 2);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
